pll_reset_sequencer: RTL and testbench

Lock-qualified reset generator that consumes the PLL `lock` output and drives the system resets. It synchronizes the asynchronous `lock`, requires it to be stable before releasing resets in two stages (core, then video), and re-asserts both resets on lock loss. It counts loss events and issues a timed PLL reset pulse if lock is never acquired. It runs on the free-running board oscillator (27 MHz), not on the PLL output.

---
 rtl/pll_reset_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Lock-qualified reset generator running on the free-running board oscillator.
// Synchronizes the raw PLL lock, waits for a stable lock before releasing the
// core reset and then the video reset, re-asserts both on lock loss, counts
// losses, and pulses the PLL reset if lock never shows up.

module pll_reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 1024,
  parameter int STAGE_GAP      = 16,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int PLL_RST_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       core_reset,
  output logic       video_reset,
  output logic       locked,
  output logic       lock_lost,
  output logic [7:0] loss_count
);

  localparam int StableW  = $clog2(STABLE_CYCLES) + 1;
  localparam int GapW     = $clog2(STAGE_GAP) + 1;
  localparam int TimeoutW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int PllW     = $clog2(PLL_RST_CYCLES) + 1;

  localparam logic [StableW-1:0]  StableLast  = StableW'(STABLE_CYCLES);
  localparam logic [GapW-1:0]     GapLast     = GapW'(STAGE_GAP);
  localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TIMEOUT_CYCLES);
  localparam logic [PllW-1:0]     PllLast     = PllW'(PLL_RST_CYCLES);

  localparam logic [StableW-1:0]  StableOne  = StableW'(1);
  localparam logic [GapW-1:0]     GapOne     = GapW'(1);
  localparam logic [TimeoutW-1:0] TimeoutOne = TimeoutW'(1);
  localparam logic [PllW-1:0]     PllOne     = PllW'(1);

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_QUAL,
    ST_STAGE,
    ST_RUN,
    ST_PLLRST
  } state_t;

  logic [SYNC_STAGES-1:0] syncChain_q;
  logic                   lockS;

  state_t state_q, state_d;

  logic [StableW-1:0]  stableCnt_q, stableCnt_d, stableInc;
  logic [GapW-1:0]     gapCnt_q, gapCnt_d, gapInc;
  logic [TimeoutW-1:0] timeoutCnt_q, timeoutCnt_d, timeoutInc;
  logic [PllW-1:0]     pllCnt_q, pllCnt_d, pllInc;

  logic       pllReset_q, pllReset_d;
  logic       coreReset_q, coreReset_d;
  logic       videoReset_q, videoReset_d;
  logic       locked_q, locked_d;
  logic       lockLost_q, lockLost_d;
  logic [7:0] lossCount_q, lossCount_d;
  logic [7:0] lossCountSat;

  assign lockS = syncChain_q[SYNC_STAGES-1];

  assign stableInc  = stableCnt_q + StableOne;
  assign gapInc     = gapCnt_q + GapOne;
  assign timeoutInc = timeoutCnt_q + TimeoutOne;
  assign pllInc     = pllCnt_q + PllOne;

  assign lossCountSat = (lossCount_q == 8'hFF) ? lossCount_q : lossCount_q + 8'd1;

  // Bring the asynchronous lock into the oscillator domain through a flop chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      syncChain_q <= '0;
    end else begin
      syncChain_q <= {syncChain_q[SYNC_STAGES-2:0], pll_lock};
    end
  end

  // Sequencer next-state, counters and registered-output next values.
  always_comb begin
    state_d      = state_q;
    stableCnt_d  = stableCnt_q;
    gapCnt_d     = gapCnt_q;
    timeoutCnt_d = timeoutCnt_q;
    pllCnt_d     = pllCnt_q;
    pllReset_d   = pllReset_q;
    coreReset_d  = coreReset_q;
    videoReset_d = videoReset_q;
    locked_d     = locked_q;
    lockLost_d   = lockLost_q;
    lossCount_d  = lossCount_q;

    unique case (state_q)
      ST_WAIT: begin
        coreReset_d  = 1'b1;
        videoReset_d = 1'b1;
        locked_d     = 1'b0;
        pllReset_d   = 1'b0;
        if (lockS) begin
          timeoutCnt_d = '0;
          gapCnt_d     = '0;
          if (STABLE_CYCLES == 1) begin
            state_d     = ST_STAGE;
            stableCnt_d = '0;
            coreReset_d = 1'b0;
          end else begin
            state_d     = ST_QUAL;
            stableCnt_d = StableOne;
          end
        end else if (timeoutInc == TimeoutLast) begin
          state_d      = ST_PLLRST;
          timeoutCnt_d = '0;
          pllCnt_d     = '0;
          pllReset_d   = 1'b1;
        end else begin
          timeoutCnt_d = timeoutInc;
        end
      end

      ST_QUAL: begin
        if (!lockS) begin
          state_d      = ST_WAIT;
          stableCnt_d  = '0;
          timeoutCnt_d = '0;
        end else if (stableInc == StableLast) begin
          state_d     = ST_STAGE;
          stableCnt_d = '0;
          gapCnt_d    = '0;
          coreReset_d = 1'b0;
        end else begin
          stableCnt_d = stableInc;
        end
      end

      ST_STAGE: begin
        if (!lockS) begin
          state_d      = ST_WAIT;
          gapCnt_d     = '0;
          timeoutCnt_d = '0;
          coreReset_d  = 1'b1;
          videoReset_d = 1'b1;
          locked_d     = 1'b0;
          lockLost_d   = 1'b1;
          lossCount_d  = lossCountSat;
        end else if (gapInc == GapLast) begin
          state_d      = ST_RUN;
          gapCnt_d     = '0;
          videoReset_d = 1'b0;
          locked_d     = 1'b1;
        end else begin
          gapCnt_d = gapInc;
        end
      end

      ST_RUN: begin
        if (!lockS) begin
          state_d      = ST_WAIT;
          timeoutCnt_d = '0;
          coreReset_d  = 1'b1;
          videoReset_d = 1'b1;
          locked_d     = 1'b0;
          lockLost_d   = 1'b1;
          lossCount_d  = lossCountSat;
        end
      end

      ST_PLLRST: begin
        if (pllInc == PllLast) begin
          state_d      = ST_WAIT;
          pllCnt_d     = '0;
          stableCnt_d  = '0;
          gapCnt_d     = '0;
          timeoutCnt_d = '0;
          pllReset_d   = 1'b0;
        end else begin
          pllCnt_d = pllInc;
        end
      end

      default: begin
        state_d      = ST_WAIT;
        stableCnt_d  = '0;
        gapCnt_d     = '0;
        timeoutCnt_d = '0;
        pllCnt_d     = '0;
        pllReset_d   = 1'b0;
        coreReset_d  = 1'b1;
        videoReset_d = 1'b1;
        locked_d     = 1'b0;
      end
    endcase
  end

  // State, counter and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_WAIT;
      stableCnt_q  <= '0;
      gapCnt_q     <= '0;
      timeoutCnt_q <= '0;
      pllCnt_q     <= '0;
      pllReset_q   <= 1'b0;
      coreReset_q  <= 1'b1;
      videoReset_q <= 1'b1;
      locked_q     <= 1'b0;
      lockLost_q   <= 1'b0;
      lossCount_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      stableCnt_q  <= stableCnt_d;
      gapCnt_q     <= gapCnt_d;
      timeoutCnt_q <= timeoutCnt_d;
      pllCnt_q     <= pllCnt_d;
      pllReset_q   <= pllReset_d;
      coreReset_q  <= coreReset_d;
      videoReset_q <= videoReset_d;
      locked_q     <= locked_d;
      lockLost_q   <= lockLost_d;
      lossCount_q  <= lossCount_d;
    end
  end

  assign pll_reset   = pllReset_q;
  assign core_reset  = coreReset_q;
  assign video_reset = videoReset_q;
  assign locked      = locked_q;
  assign lock_lost   = lockLost_q;
  assign loss_count  = lossCount_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer: directed and random lock patterns,
// reference model queues expected outputs, a monitor compares each cycle.

module tb_pll_reset_sequencer;

  localparam int SyncStages    = 2;
  localparam int StableCycles  = 8;
  localparam int StageGap      = 4;
  localparam int TimeoutCycles = 32;
  localparam int PllRstCycles  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pllLock = 1'b0;
  logic       pllReset;
  logic       coreReset;
  logic       videoReset;
  logic       locked;
  logic       lockLost;
  logic [7:0] lossCount;

  typedef struct packed {
    logic       pllReset;
    logic       coreReset;
    logic       videoReset;
    logic       locked;
    logic       lockLost;
    logic [7:0] lossCount;
  } expect_t;

  expect_t expQ[$];

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int monCycle = 0;

  bit mPipe[SyncStages];
  int highRun = 0;
  int lowRun = 0;
  int pllLeft = 0;
  int mLossCnt = 0;
  bit mLost = 1'b0;

  pll_reset_sequencer #(
    .SYNC_STAGES(SyncStages),
    .STABLE_CYCLES(StableCycles),
    .STAGE_GAP(StageGap),
    .TIMEOUT_CYCLES(TimeoutCycles),
    .PLL_RST_CYCLES(PllRstCycles)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pll_lock(pllLock),
    .pll_reset(pllReset),
    .core_reset(coreReset),
    .video_reset(videoReset),
    .locked(locked),
    .lock_lost(lockLost),
    .loss_count(lossCount)
  );

  always #5 clk = ~clk;

  // Behavioural model: the sequencer is described by how many consecutive
  // qualified-lock observations have been seen since the last disruption.
  task automatic modelEdge(input logic rstVal, input logic lockVal);
    bit obs;
    if (rstVal) begin
      for (int i = 0; i < SyncStages; i++) mPipe[i] = 1'b0;
      highRun = 0;
      lowRun = 0;
      pllLeft = 0;
      mLossCnt = 0;
      mLost = 1'b0;
    end else begin
      obs = mPipe[SyncStages-1];
      for (int i = SyncStages - 1; i > 0; i--) mPipe[i] = mPipe[i-1];
      mPipe[0] = lockVal;
      if (pllLeft > 0) begin
        pllLeft--;
      end else if (obs) begin
        lowRun = 0;
        if (highRun < StableCycles + StageGap) highRun++;
      end else if (highRun > 0) begin
        if (highRun >= StableCycles) begin
          mLost = 1'b1;
          if (mLossCnt < 255) mLossCnt++;
        end
        highRun = 0;
        lowRun = 0;
      end else begin
        lowRun++;
        if (lowRun == TimeoutCycles) begin
          lowRun = 0;
          pllLeft = PllRstCycles;
        end
      end
    end
  endtask

  // Drive one clock of inputs and queue the outputs expected after that edge.
  task automatic applyStimulus(input logic rstVal, input logic lockVal);
    expect_t e;
    @(negedge clk);
    reset = rstVal;
    pllLock = lockVal;
    cycle++;
    modelEdge(rstVal, lockVal);
    e.pllReset   = (pllLeft > 0);
    e.coreReset  = (highRun < StableCycles);
    e.videoReset = (highRun < StableCycles + StageGap);
    e.locked     = (highRun >= StableCycles + StageGap);
    e.lockLost   = mLost;
    e.lossCount  = 8'(mLossCnt);
    expQ.push_back(e);
  endtask

  task automatic holdLock(input logic lockVal, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, lockVal);
  endtask

  task automatic checkOne(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d got %0d expected %0d", name, monCycle, act, exp);
    end
  endtask

  task automatic checkOutput(input expect_t e);
    checkOne("pll_reset", {7'd0, pllReset}, {7'd0, e.pllReset});
    checkOne("core_reset", {7'd0, coreReset}, {7'd0, e.coreReset});
    checkOne("video_reset", {7'd0, videoReset}, {7'd0, e.videoReset});
    checkOne("locked", {7'd0, locked}, {7'd0, e.locked});
    checkOne("lock_lost", {7'd0, lockLost}, {7'd0, e.lockLost});
    checkOne("loss_count", lossCount, e.lossCount);
  endtask

  // Monitor: after every active edge, pop the expected response and compare.
  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        monCycle++;
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog cycle %0d got timeout expected finish", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

  // Stimulus sequence.
  initial begin
    int lenVal;
    logic lvl;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    $display("[TB] lock from release");
    holdLock(1'b1, 20);
    $display("[TB] loss in RUN and relock");
    holdLock(1'b0, 6);
    holdLock(1'b1, 20);

    $display("[TB] short low glitch during qualification");
    applyStimulus(1'b1, 1'b0);
    holdLock(1'b1, 5);
    holdLock(1'b0, 1);
    holdLock(1'b1, 20);

    $display("[TB] lock held low, PLL reset pulses");
    applyStimulus(1'b1, 1'b0);
    holdLock(1'b0, 80);

    $display("[TB] loss during STAGE");
    applyStimulus(1'b1, 1'b0);
    holdLock(1'b1, 8);
    holdLock(1'b0, 4);
    holdLock(1'b1, 20);

    $display("[TB] repeated lock/loss to saturate loss_count");
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      holdLock(1'b1, $urandom_range(12, 8));
      holdLock(1'b0, $urandom_range(3, 1));
    end
    holdLock(1'b1, 16);
    $display("[TB] reset asserted mid-RUN");
    applyStimulus(1'b1, 1'b1);
    holdLock(1'b1, 16);

    $display("[TB] random lock segments");
    lvl = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(19, 0) == 0) applyStimulus(1'b1, lvl);
      lvl = ~lvl;
      lenVal = $urandom_range(45, 1);
      holdLock(lvl, lenVal);
    end

    @(posedge clk);
    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain cycle %0d got %0d pending expected 0", cycle, expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
